// File: rtl/axi_sram_responder_if.sv
// AXI4 request/response bundle types and the interface that carries them
// between the initiating core and the SRAM responder.
package ariane_axi;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned StrbWidth = DataWidth / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [5:0]           atop;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;
endpackage

// Every channel uses valid/ready: a beat transfers on a rising edge where both
// are high; a source never drops valid or changes payload until that edge.
interface axi_sram_responder_if;
    ariane_axi::req_t  noc_req_i;
    ariane_axi::resp_t noc_resp_o;

    modport master (output noc_req_i, input noc_resp_o);
    modport slave  (input noc_req_i, output noc_resp_o);
endinterface

// File: rtl/axi_sram_responder.sv
// AXI4 subordinate backed by a single-port SRAM: one transaction at a time,
// FIXED/INCR bursts with byte strobes, SLVERR for anything it cannot serve.
module axi_sram_responder #(
    parameter int unsigned AxiAddrWidth = ariane_axi::AddrWidth,
    parameter int unsigned AxiDataWidth = ariane_axi::DataWidth,
    parameter int unsigned AxiIdWidth   = ariane_axi::IdWidth,
    parameter type         noc_req_t    = ariane_axi::req_t,
    parameter type         noc_resp_t   = ariane_axi::resp_t,
    parameter int unsigned NumWords     = 1024,
    parameter logic [AxiAddrWidth-1:0] BaseAddr = AxiAddrWidth'(64'h8000_0000)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    axi_sram_responder_if.slave  noc,
    output logic [1:0]           dbg_state_o
);
    import ariane_axi::BURST_FIXED;
    import ariane_axi::BURST_INCR;
    import ariane_axi::RESP_OKAY;
    import ariane_axi::RESP_SLVERR;

    localparam int unsigned StrbWidth = AxiDataWidth / 8;
    localparam int unsigned OffBits   = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = (NumWords > 1) ? $clog2(NumWords) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, WRITE_RESP} state_e;

    noc_req_t  req;
    noc_resp_t rsp;

    assign req            = noc.noc_req_i;
    assign noc.noc_resp_o = rsp;

    state_e                  state_q, state_d;
    logic [AxiIdWidth-1:0]   id_q, id_d;
    logic [AxiAddrWidth-1:0] addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    prio_write_q, prio_write_d;

    logic [AxiDataWidth-1:0] mem_q [NumWords];

    logic [AxiAddrWidth-1:0] offset;
    logic [AxiAddrWidth-1:0] word_addr;
    logic [AxiAddrWidth-1:0] step;
    logic [AxiAddrWidth-1:0] next_addr;
    logic [IdxWidth-1:0]     idx;
    logic                    addr_err;
    logic                    beat_err;
    logic                    take_read;
    logic                    take_write;
    logic                    r_last;
    logic                    mem_we;

    function automatic logic hdr_err(input logic [1:0] burst, input logic [2:0] size);
        return !(burst == BURST_FIXED || burst == BURST_INCR) || (32'(size) > OffBits);
    endfunction

    // Address decode and burst advance for the beat currently being served.
    always_comb begin
        offset    = addr_q - BaseAddr;
        word_addr = offset >> OffBits;
        addr_err  = (addr_q < BaseAddr) || (word_addr >= AxiAddrWidth'(NumWords));
        idx       = word_addr[IdxWidth-1:0];
        step      = AxiAddrWidth'(1) << size_q;
        if (burst_q == BURST_FIXED) begin
            next_addr = addr_q;
        end else begin
            next_addr = (addr_q & ~(step - AxiAddrWidth'(1))) + step;
        end
        beat_err = err_q || addr_err;
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        burst_d      = burst_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        prio_write_d = prio_write_q;
        rsp          = '0;
        take_read    = 1'b0;
        take_write   = 1'b0;
        r_last       = 1'b0;
        mem_we       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Readies stay low while reset is held even though the state is IDLE.
                if (rst_ni) begin
                    take_read  = req.ar_valid && (!req.aw_valid || !prio_write_q);
                    take_write = req.aw_valid && (!req.ar_valid || prio_write_q);
                end
                rsp.ar_ready = take_read;
                rsp.aw_ready = take_write;
                if (take_read) begin
                    id_d    = req.ar.id;
                    addr_d  = req.ar.addr;
                    len_d   = req.ar.len;
                    size_d  = req.ar.size;
                    burst_d = req.ar.burst;
                    cnt_d   = '0;
                    err_d   = hdr_err(req.ar.burst, req.ar.size);
                    state_d = READ;
                end else if (take_write) begin
                    id_d    = req.aw.id;
                    addr_d  = req.aw.addr;
                    len_d   = req.aw.len;
                    size_d  = req.aw.size;
                    burst_d = req.aw.burst;
                    cnt_d   = '0;
                    err_d   = hdr_err(req.aw.burst, req.aw.size) || (req.aw.atop != '0);
                    state_d = WRITE;
                end
                // Round-robin only matters when both channels compete; the loser
                // of a contested cycle wins the next contest.
                if (rst_ni && req.ar_valid && req.aw_valid) begin
                    prio_write_d = take_read;
                end
            end
            READ: begin
                r_last         = (cnt_q == len_q);
                rsp.r_valid    = 1'b1;
                rsp.r.id       = id_q;
                rsp.r.last     = r_last;
                rsp.r.resp     = beat_err ? RESP_SLVERR : RESP_OKAY;
                rsp.r.data     = beat_err ? '0 : mem_q[idx];
                if (req.r_ready) begin
                    addr_d = next_addr;
                    cnt_d  = cnt_q + 8'd1;
                    if (r_last) begin
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                rsp.w_ready = 1'b1;
                if (req.w_valid) begin
                    mem_we = !beat_err;
                    err_d  = beat_err;
                    addr_d = next_addr;
                    cnt_d  = cnt_q + 8'd1;
                    if (req.w.last) begin
                        state_d = WRITE_RESP;
                    end
                end
            end
            WRITE_RESP: begin
                rsp.b_valid = 1'b1;
                rsp.b.id    = id_q;
                rsp.b.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (req.b_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            prio_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            prio_write_q <= prio_write_d;
        end
    end

    // SRAM array has no reset: contents survive a reset of the control logic.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
                if (req.w.strb[b]) begin
                    mem_q[idx][8*b +: 8] <= req.w.data[8*b +: 8];
                end
            end
        end
    end

    assign dbg_state_o = state_q;

endmodule
